// File: rtl/snn_feeder_pkg.sv
// -----------------------------------------------------------------------------
// snn_feeder_pkg
// Shared definitions for sample_spike_feeder and its rate/accumulator bank:
//   - FSM state constants (3-bit encoding, exposed on the top's state_dbg port)
//   - width helpers for channel index, step counter and accumulator
//   - THRESH legality check used at elaboration
// -----------------------------------------------------------------------------
package snn_feeder_pkg;

   typedef logic [2:0] feeder_state_t;

   localparam feeder_state_t ST_IDLE     = 3'd0;
   localparam feeder_state_t ST_LOAD     = 3'd1;
   localparam feeder_state_t ST_START    = 3'd2;
   localparam feeder_state_t ST_SCAN     = 3'd3;
   localparam feeder_state_t ST_WAIT_ACK = 3'd4;
   localparam feeder_state_t ST_DONE     = 3'd5;

   // Index widths never collapse to zero bits, even for a single channel/step.
   function automatic int ch_w(input int num_in);
      return (num_in > 1) ? $clog2(num_in) : 1;
   endfunction

   function automatic int step_w(input int num_steps);
      return (num_steps > 1) ? $clog2(num_steps) : 1;
   endfunction

   // One extra bit so acc + rate never wraps while acc < THRESH <= 2**DATA_W.
   function automatic int acc_w(input int data_w);
      return data_w + 1;
   endfunction

   function automatic int cnt_w(input int num_in, input int num_steps);
      return $clog2(num_in * num_steps + 1);
   endfunction

   function automatic bit thresh_ok(input int thresh, input int data_w);
      return (thresh >= 1) && (thresh <= (1 << data_w));
   endfunction

endpackage

// File: rtl/sample_spike_feeder_bank.sv
// -----------------------------------------------------------------------------
// rate_acc_bank
// Per-channel storage for one sample: rate[] (loaded once) and acc[] (the
// integrate-and-fire membrane). Two ports, never active in the same cycle:
//   ld_en/ld_idx/ld_data    : store a rate and clear that channel's acc
//   scan_en/scan_idx        : read-modify-write of acc[scan_idx]
// Outputs (combinational from scan_idx):
//   spike    : acc + rate reached THRESH
//   acc_next : value written back to acc when scan_en is high
// Ports: clk, rst_n (sync, active low), the two ports above, spike, acc_next.
// -----------------------------------------------------------------------------
module rate_acc_bank
   import snn_feeder_pkg::*;
#(
   parameter int NUM_IN = 20,
   parameter int DATA_W = 8,
   parameter int THRESH = 256
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ld_en,
   input  logic [ch_w(NUM_IN)-1:0]    ld_idx,
   input  logic [DATA_W-1:0]          ld_data,
   input  logic                       scan_en,
   input  logic [ch_w(NUM_IN)-1:0]    scan_idx,
   output logic                       spike,
   output logic [acc_w(DATA_W)-1:0]   acc_next
);

   localparam int ACC_W = acc_w(DATA_W);
   localparam logic [ACC_W-1:0] TH    = ACC_W'(THRESH);
   localparam logic [ACC_W-1:0] TH_M1 = ACC_W'(THRESH - 1);

   logic [DATA_W-1:0] rate [NUM_IN];
   logic [ACC_W-1:0]  acc  [NUM_IN];
   logic [ACC_W-1:0]  sum;
   logic [ACC_W-1:0]  diff;

   always_comb begin
      sum      = acc[scan_idx] + {1'b0, rate[scan_idx]};
      diff     = sum - TH;
      spike    = (sum >= TH);
      // The clamp keeps acc below THRESH, so a rate at or above THRESH can
      // never owe more than one spike per step.
      acc_next = sum;
      if (spike) acc_next = (diff > TH_M1) ? TH_M1 : diff;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_IN; i++) begin
            rate[i] <= '0;
            acc[i]  <= '0;
         end
      end else if (ld_en) begin
         rate[ld_idx] <= ld_data;
         acc[ld_idx]  <= '0;
      end else if (scan_en) begin
         acc[scan_idx] <= acc_next;
      end
   end

endmodule

// File: rtl/sample_spike_feeder.sv
// -----------------------------------------------------------------------------
// sample_spike_feeder
// Responder side of the inter-layer handshake. On rqt_new_sample it loads
// NUM_IN rates from an upstream stream, pulses trans_start, then runs
// NUM_STEPS timesteps of serial integrate-and-fire encoding (one channel per
// cycle). Each spike is presented on spk_in/spk_addr and held until spk_done.
// steps_done pulses once the last timestep finishes.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   rqt_new_sample    controller ready for a new sample (level)
//   s_valid/s_data    upstream rate beats, channel 0 first
//   s_ready           feeder accepts a beat
//   trans_start       1-cycle pulse: sample loaded, encoding starts
//   spk_in/spk_addr   1-cycle spike pulse / channel, addr held until spk_done
//   spk_done          second layer finished the current spike
//   steps_done        1-cycle pulse: all timesteps complete
//   spk_count         (only with SPK_COUNT_EN) spikes emitted this sample
//   state_dbg         current FSM state
//
// Handshake: a beat transfers on a rising edge where s_valid && s_ready are
// both high. s_ready is high only in LOAD and does not depend on s_valid;
// s_valid seen while s_ready is low is ignored.
//
// Build option: define SPK_COUNT_EN to add the spk_count output.
// -----------------------------------------------------------------------------
module sample_spike_feeder
   import snn_feeder_pkg::*;
#(
   parameter int NUM_IN    = 20,
   parameter int DATA_W    = 8,
   parameter int NUM_STEPS = 16,
   parameter int THRESH    = 256
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                rqt_new_sample,
   input  logic                                s_valid,
   input  logic [DATA_W-1:0]                   s_data,
   output logic                                s_ready,
   output logic                                trans_start,
   output logic                                spk_in,
   output logic [ch_w(NUM_IN)-1:0]             spk_addr,
   input  logic                                spk_done,
   output logic                                steps_done,
`ifdef SPK_COUNT_EN
   output logic [cnt_w(NUM_IN,NUM_STEPS)-1:0]  spk_count,
`endif
   output logic [2:0]                          state_dbg
);

   localparam int CH_W   = ch_w(NUM_IN);
   localparam int STEP_W = step_w(NUM_STEPS);
   localparam int ACC_W  = acc_w(DATA_W);
   localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_IN - 1);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

   if (!thresh_ok(THRESH, DATA_W)) begin : g_bad_thresh
      $error("sample_spike_feeder: THRESH must be in 1..2**DATA_W");
   end

   feeder_state_t     state;
   logic [CH_W-1:0]   ld_idx;
   logic [CH_W-1:0]   ch;
   logic [STEP_W-1:0] step;
   logic              ld_en;
   logic              scan_en;
   logic              spike;
   logic [ACC_W-1:0]  acc_next;
   logic              advance;

   assign ld_en     = (state == ST_LOAD) && s_valid && s_ready;
   assign scan_en   = (state == ST_SCAN);
   assign state_dbg = state;

   // Move to the next channel: either a quiet SCAN cycle or an acknowledged
   // spike. spk_done in any other state is ignored here.
   assign advance = (scan_en && !spike) || ((state == ST_WAIT_ACK) && spk_done);

   rate_acc_bank #(
      .NUM_IN (NUM_IN),
      .DATA_W (DATA_W),
      .THRESH (THRESH)
   ) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .ld_en    (ld_en),
      .ld_idx   (ld_idx),
      .ld_data  (s_data),
      .scan_en  (scan_en),
      .scan_idx (ch),
      .spike    (spike),
      .acc_next (acc_next)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         s_ready     <= 1'b0;
         trans_start <= 1'b0;
         spk_in      <= 1'b0;
         steps_done  <= 1'b0;
         spk_addr    <= '0;
         ld_idx      <= '0;
         ch          <= '0;
         step        <= '0;
      end else begin
         // Pulse outputs are high only for the cycle after they are set.
         trans_start <= 1'b0;
         spk_in      <= 1'b0;
         steps_done  <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (rqt_new_sample) begin
                  state   <= ST_LOAD;
                  s_ready <= 1'b1;
                  ld_idx  <= '0;
               end
            end
            ST_LOAD: begin
               if (ld_en) begin
                  ld_idx <= ld_idx + 1'b1;
                  if (ld_idx == LAST_CH) begin
                     s_ready     <= 1'b0;
                     trans_start <= 1'b1;
                     state       <= ST_START;
                  end
               end
            end
            ST_START: begin
               step  <= '0;
               ch    <= '0;
               state <= ST_SCAN;
            end
            ST_SCAN: begin
               if (spike) begin
                  spk_in   <= 1'b1;
                  spk_addr <= ch;
                  state    <= ST_WAIT_ACK;
               end
            end
            ST_WAIT_ACK: ;
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase

         if (advance) begin
            if (ch != LAST_CH) begin
               ch    <= ch + 1'b1;
               state <= ST_SCAN;
            end else begin
               ch <= '0;
               if (step != LAST_STEP) begin
                  step  <= step + 1'b1;
                  state <= ST_SCAN;
               end else begin
                  steps_done <= 1'b1;
                  state      <= ST_DONE;
               end
            end
         end
      end
   end

`ifdef SPK_COUNT_EN
   // Cleared when a new sample starts, frozen from steps_done to next START.
   always_ff @(posedge clk) begin
      if (!rst_n)                spk_count <= '0;
      else if (state == ST_START) spk_count <= '0;
      else if (scan_en && spike)  spk_count <= spk_count + 1'b1;
   end
`endif

endmodule

// File: tb/tb_sample_spike_feeder.sv
`timescale 1ns/1ps
module tb_sample_spike_feeder;

   localparam int NI = 4;
   localparam int NS = 4;
   localparam int DW = 8;
   localparam int CW = 2;
   localparam int KW = 5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- stimulus and DUT wiring ----------------
   logic          sel = 1'b0;   // 0: THRESH=256 instance, 1: THRESH=100 instance
   logic          rqt = 1'b0;
   logic          s_valid = 1'b0;
   logic          spk_done = 1'b0;
   logic [DW-1:0] s_data = '0;

   logic rqt_a, rqt_b, sv_a, sv_b, sd_a, sd_b;
   logic s_ready_a, trans_start_a, spk_in_a, steps_done_a;
   logic s_ready_b, trans_start_b, spk_in_b, steps_done_b;
   logic [CW-1:0] spk_addr_a, spk_addr_b, spk_addr_m;
   logic [2:0] st_a, st_b, st_m;
   logic s_ready_m, trans_start_m, spk_in_m, steps_done_m;
`ifdef SPK_COUNT_EN
   logic [KW-1:0] spk_count_a, spk_count_b, spk_count_m;
   assign spk_count_m = sel ? spk_count_b : spk_count_a;
`endif

   assign rqt_a = rqt && !sel;       assign rqt_b = rqt && sel;
   assign sv_a  = s_valid && !sel;   assign sv_b  = s_valid && sel;
   assign sd_a  = spk_done && !sel;  assign sd_b  = spk_done && sel;
   assign s_ready_m     = sel ? s_ready_b     : s_ready_a;
   assign trans_start_m = sel ? trans_start_b : trans_start_a;
   assign spk_in_m      = sel ? spk_in_b      : spk_in_a;
   assign steps_done_m  = sel ? steps_done_b  : steps_done_a;
   assign spk_addr_m    = sel ? spk_addr_b    : spk_addr_a;
   assign st_m          = sel ? st_b          : st_a;

   sample_spike_feeder #(.NUM_IN(NI), .DATA_W(DW), .NUM_STEPS(NS), .THRESH(256)) dut_a (
      .clk(clk), .rst_n(rst_n), .rqt_new_sample(rqt_a), .s_valid(sv_a), .s_data(s_data),
      .s_ready(s_ready_a), .trans_start(trans_start_a), .spk_in(spk_in_a),
      .spk_addr(spk_addr_a), .spk_done(sd_a), .steps_done(steps_done_a),
`ifdef SPK_COUNT_EN
      .spk_count(spk_count_a),
`endif
      .state_dbg(st_a)
   );

   sample_spike_feeder #(.NUM_IN(NI), .DATA_W(DW), .NUM_STEPS(NS), .THRESH(100)) dut_b (
      .clk(clk), .rst_n(rst_n), .rqt_new_sample(rqt_b), .s_valid(sv_b), .s_data(s_data),
      .s_ready(s_ready_b), .trans_start(trans_start_b), .spk_in(spk_in_b),
      .spk_addr(spk_addr_b), .spk_done(sd_b), .steps_done(steps_done_b),
`ifdef SPK_COUNT_EN
      .spk_count(spk_count_b),
`endif
      .state_dbg(st_b)
   );

   // ---------------- bookkeeping ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Expected spike channels in order, from plain integrate-and-fire arithmetic.
   logic [CW-1:0] exp_q[$];
   int seen_spikes = 0;

   function automatic void build_model(input int r[NI], input int th);
      int acc[NI];
      exp_q.delete();
      for (int c = 0; c < NI; c++) acc[c] = 0;
      for (int s = 0; s < NS; s++)
         for (int c = 0; c < NI; c++) begin
            acc[c] += r[c];
            if (acc[c] >= th) begin
               exp_q.push_back(CW'(c));
               acc[c] -= th;
               if (acc[c] > th - 1) acc[c] = th - 1;
            end
         end
   endfunction

   // ---------------- scoreboard compare process ----------------
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (spk_in_m) begin
            seen_spikes++;
            chk("spike_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("spk_addr", int'(spk_addr_m), int'(exp_q.pop_front()));
         end
         if (steps_done_m) begin
            chk("no_spk_with_done", int'(spk_in_m), 0);
            chk("spikes_left_at_done", exp_q.size(), 0);
         end
      end
   end

   // ---------------- spike acknowledge driver ----------------
   int   ack_delay = 1;
   bit   spur_en = 1'b0;
   bit   ack_busy = 1'b0;
   logic [CW-1:0] hold_addr;

   initial forever begin
      @(negedge clk);
      if (rst_n && spk_in_m) begin
         ack_busy  = 1'b1;
         hold_addr = spk_addr_m;
         for (int k = 1; k <= ack_delay; k++) begin
            @(posedge clk); #1;
            if (k == ack_delay) spk_done = 1'b1;
            @(negedge clk);
            chk("addr_held", int'(spk_addr_m), int'(hold_addr));
            chk("no_spk_in_wait", int'(spk_in_m), 0);
         end
         @(posedge clk); #1;
         // Optionally leave spk_done high into the following SCAN cycle.
         if (spur_en) begin @(posedge clk); #1; end
         spk_done = 1'b0;
         ack_busy = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic load_sample(input int r[NI], input int gap, input bit drop);
      int t;
      // junk beat while idle must be ignored
      @(posedge clk); #1; s_valid = 1'b1; s_data = 8'hA5;
      @(negedge clk);
      chk("s_ready_idle", int'(s_ready_m), 0);
      @(posedge clk); #1; s_valid = 1'b0; rqt = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!s_ready_m && t < 20);
      chk("s_ready_load", int'(s_ready_m), 1);
      for (int c = 0; c < NI; c++) begin
         for (int g = 0; g < gap; g++) begin @(posedge clk); #1; s_valid = 1'b0; end
         @(posedge clk); #1; s_valid = 1'b1; s_data = DW'(r[c]);
         if (drop && c == 1) rqt = 1'b0;
      end
      @(posedge clk); #1; s_valid = 1'b0; s_data = 8'h5A;
      @(negedge clk);
      chk("trans_start_after_last_beat", int'(trans_start_m), 1);
      chk("s_ready_dropped", int'(s_ready_m), 0);
      rqt = 1'b0;
   endtask

   task automatic run_to_done(input int exp_lat, input int exp_spk);
      int n;
      @(negedge clk); n = 1;
      chk("trans_start_one_cycle", int'(trans_start_m), 0);
      while (!steps_done_m && n < 3000) begin @(negedge clk); n++; end
      chk("done_latency", n, exp_lat);
      chk("spike_total", seen_spikes, exp_spk);
`ifdef SPK_COUNT_EN
      chk("spk_count", int'(spk_count_m), exp_spk);
`endif
      @(negedge clk);
      chk("steps_done_one_cycle", int'(steps_done_m), 0);
      chk("state_idle_after_done", int'(st_m), 0);
   endtask

   task automatic wait_ack_idle();
      int t = 0;
      while (ack_busy && t < 100) begin @(negedge clk); t++; end
      chk("ack_driver_idle", int'(ack_busy), 0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_s_ready"}, int'(s_ready_a), 0);
      chk({tag, "_trans_start"}, int'(trans_start_a), 0);
      chk({tag, "_spk_in"}, int'(spk_in_a), 0);
      chk({tag, "_spk_addr"}, int'(spk_addr_a), 0);
      chk({tag, "_steps_done"}, int'(steps_done_a), 0);
      chk({tag, "_state"}, int'(st_a), 0);
   endtask

   // ---------------- main sequence ----------------
   int r1[NI] = '{128, 0, 255, 64};
   int r0[NI] = '{0, 0, 0, 0};
   int r5[NI] = '{255, 0, 0, 0};
   int order1[6] = '{0, 2, 2, 0, 2, 3};

   initial begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1; rst_n = 1'b1;

      // pin the model against hand-derived results
      build_model(r1, 256);
      chk("model_s1_count", exp_q.size(), 6);
      for (int i = 0; i < 6; i++) chk("model_s1_order", int'(exp_q[i]), order1[i]);
      build_model(r5, 100);
      chk("model_th100_count", exp_q.size(), 4);

      // 1: basic sample, 1-cycle ack
      build_model(r1, 256); seen_spikes = 0;
      load_sample(r1, 0, 1'b0);
      run_to_done(29, 6);
      wait_ack_idle();

      // 2: valid every 3rd cycle, rqt dropped after first beat
      build_model(r1, 256); seen_spikes = 0;
      load_sample(r1, 2, 1'b1);
      run_to_done(29, 6);
      wait_ack_idle();

      // 3: all-zero sample
      build_model(r0, 256); seen_spikes = 0;
      chk("model_zero_count", exp_q.size(), 0);
      load_sample(r0, 0, 1'b0);
      run_to_done(17, 0);

      // 4: slow ack (10 cycles) plus spk_done lingering into SCAN
      ack_delay = 10; spur_en = 1'b1;
      build_model(r1, 256); seen_spikes = 0;
      load_sample(r1, 0, 1'b0);
      run_to_done(83, 6);
      wait_ack_idle();
      ack_delay = 1; spur_en = 1'b0;

      // 5: THRESH=100 instance, rate 255 on ch0
      sel = 1'b1;
      build_model(r5, 100); seen_spikes = 0;
      load_sample(r5, 0, 1'b0);
      run_to_done(25, 4);
      wait_ack_idle();
      sel = 1'b0;

      // 6: reset pulse while waiting for an ack, then a clean rerun
      ack_delay = 5;
      build_model(r1, 256); seen_spikes = 0;
      load_sample(r1, 0, 1'b0);
      begin
         int t = 0;
         while (!spk_in_m && t < 200) begin @(negedge clk); t++; end
         chk("first_spike_seen", int'(spk_in_m), 1);
      end
      @(posedge clk); #1; rst_n = 1'b0;
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("midreset");
      exp_q.delete();
      wait_ack_idle();
      chk("idle_after_reset_ack", int'(st_a), 0);
      ack_delay = 1;
      build_model(r1, 256); seen_spikes = 0;
      load_sample(r1, 0, 1'b0);
      run_to_done(29, 6);
      wait_ack_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
